// File: rtl/vga_linebuf_display.sv
// VGA engine: pixel divider, H/V sync, double-buffered palette-index line buffer, 16x12b palette.
// Outputs settle one clk after pix_en; cmd_ready stays low while a completed line awaits its swap.
module vga_linebuf_display #(
  parameter int   TICK_DIV  = 3,
  parameter int   H_VIS     = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_VIS     = 600,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 23,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   BPP       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       line_swap
);

  localparam int LINE_BYTES = H_VIS * BPP / 8;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW    = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int BSH   = $clog2(BPP);

  localparam logic [TW-1:0] T_LAST   = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [AW-1:0] W_LAST   = AW'(LINE_BYTES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PAL_HI = 2'd1;
  localparam logic [1:0] S_PAL_LO = 2'd2;
  localparam logic [1:0] S_LINE   = 2'd3;

  logic [TW-1:0] tick;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          pix_en;
  logic          vis, hs_act, vs_act;
  logic [HW+2:0] bit_pos;
  logic [AW-1:0] rd_addr;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    pal_sel;
  logic [3:0]    pal_r;
  logic          pending, front_valid, bank_sel;
  logic          accept, wr_en;
  logic [11:0]   palette [16];
  logic [7:0]    linebuf [2][LINE_BYTES];

  logic [7:0]    ram_q;
  logic          p1, s1_vis, s1_hs, s1_vs, s1_fv;
  logic [2:0]    s1_off;
  logic [7:0]    shifted;
  logic [3:0]    pix_idx;

  assign pix_en    = (tick == '0);
  assign vis       = (hcount < H_VIS_C) && (vcount < V_VIS_C);
  assign hs_act    = (hcount >= HS_START) && (hcount < HS_END);
  assign vs_act    = (vcount >= VS_START) && (vcount < VS_END);
  assign bit_pos   = {3'b000, hcount} << BSH;
  assign rd_addr   = vis ? AW'(bit_pos[HW+2:3]) : '0;
  assign cmd_ready = !rst && !pending;
  assign accept    = cmd_valid && cmd_ready;
  assign wr_en     = accept && (state == S_LINE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick   <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      tick <= (tick == T_LAST) ? '0 : tick + 1'b1;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  // Writes always target the back bank; reads the front bank one pixel ahead of the outputs.
  always_ff @(posedge clk) begin
    if (wr_en) linebuf[~bank_sel][wr_ptr] <= cmd_data;
    if (pix_en) ram_q <= linebuf[bank_sel][rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      pal_sel     <= '0;
      pal_r       <= '0;
      pending     <= 1'b0;
      front_valid <= 1'b0;
      bank_sel    <= 1'b0;
      line_swap   <= 1'b0;
      for (int i = 0; i < 16; i++) palette[i] <= '0;
      palette[0]  <= 12'h208;
      palette[1]  <= 12'hFF0;
    end else begin
      line_swap <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (cmd_data[7:4] == 4'h1) begin
              pal_sel <= cmd_data[3:0];
              state   <= S_PAL_HI;
            end else if (cmd_data == 8'h20) begin
              wr_ptr <= '0;
              state  <= S_LINE;
            end
          end
          S_PAL_HI: begin
            pal_r <= cmd_data[3:0];
            state <= S_PAL_LO;
          end
          S_PAL_LO: begin
            palette[pal_sel] <= {pal_r, cmd_data};
            state            <= S_IDLE;
          end
          default: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == W_LAST) begin
              pending <= 1'b1;
              state   <= S_IDLE;
            end
          end
        endcase
      end
      // pending blocks accept, so a swap never coincides with a line write
      if (pix_en && (hcount == HS_START) && pending) begin
        bank_sel    <= ~bank_sel;
        pending     <= 1'b0;
        front_valid <= 1'b1;
        line_swap   <= 1'b1;
      end
    end
  end

  assign shifted = ram_q << s1_off;

  always_comb begin
    pix_idx = '0;
    pix_idx[BPP-1:0] = shifted[7 -: BPP];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1     <= 1'b0;
      s1_vis <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_fv  <= 1'b0;
      s1_off <= '0;
      hsync  <= !HSYNC_POL;
      vsync  <= !VSYNC_POL;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else begin
      p1 <= pix_en;
      if (pix_en) begin
        s1_vis <= vis;
        s1_hs  <= hs_act;
        s1_vs  <= vs_act;
        s1_fv  <= front_valid;
        s1_off <= bit_pos[2:0];
      end
      if (p1) begin
        hsync <= s1_hs ? HSYNC_POL : !HSYNC_POL;
        vsync <= s1_vs ? VSYNC_POL : !VSYNC_POL;
        {red, green, blue} <= s1_vis ? (s1_fv ? palette[pix_idx] : palette[0]) : 12'h000;
      end
    end
  end

endmodule
